// File: rtl/melody_pkg.sv
// Shared types and the default tune for the melody player.
// A note is a tone frequency plus how long it sounds.
package melody_pkg;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] dur_ms;
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEFAULT_NOTES = 8;

    // C major scale from C4 up to C5, a quarter second per note
    localparam note_t [0:DEFAULT_NOTES-1] DEFAULT_TABLE = '{
        '{freq: 32'd262, dur_ms: 16'd250},
        '{freq: 32'd294, dur_ms: 16'd250},
        '{freq: 32'd330, dur_ms: 16'd250},
        '{freq: 32'd349, dur_ms: 16'd250},
        '{freq: 32'd392, dur_ms: 16'd250},
        '{freq: 32'd440, dur_ms: 16'd250},
        '{freq: 32'd494, dur_ms: 16'd250},
        '{freq: 32'd523, dur_ms: 16'd250}
    };

endpackage

// File: rtl/ms_timer.sv
// Counts whole milliseconds since the last clear.
// ms_wrap flags the final clock cycle of each millisecond.
module ms_timer #(
    parameter int FCLK = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    output logic [15:0] ms_count,
    output logic        ms_wrap
);

    localparam int TICKS = FCLK / 1000;
    localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [TW-1:0] tick;

    assign ms_wrap = en && (tick == TW'(TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick     <= '0;
            ms_count <= '0;
        end else if (clear) begin
            tick     <= '0;
            ms_count <= '0;
        end else if (en) begin
            if (ms_wrap) begin
                tick     <= '0;
                ms_count <= ms_count + 16'd1;
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

endmodule

// File: rtl/melody_player.sv
// Walks a note table and drives the tone generator's freq/onOff inputs,
// inserting a silent gap after each note and optionally looping.
module melody_player
    import melody_pkg::*;
#(
    parameter int                  FCLK   = 50_000_000,
    parameter int                  NOTES  = 8,
    parameter int                  GAP_MS = 20,
    parameter note_t [0:NOTES-1]   TABLE  = DEFAULT_TABLE
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic                                   stop,
    input  logic                                   loop,
    output logic [31:0]                            freq,
    output logic                                   onOff,
    output logic                                   busy,
    output logic [((NOTES > 1) ? $clog2(NOTES) : 1)-1:0] note_idx,
    output logic                                   done
);

    localparam int NIW     = (NOTES > 1) ? $clog2(NOTES) : 1;
    localparam bit HAS_GAP = (GAP_MS > 0);

    state_t         state;
    logic [15:0]    ms_count;
    logic           ms_wrap;
    logic [15:0]    dur_eff;
    logic [15:0]    target_ms;
    logic           phase_end;
    logic           advance;
    logic           last_note;
    logic [NIW-1:0] next_idx;
    logic           timer_clear;
    logic           timer_en;

    // A zero duration still sounds for one millisecond
    always_comb begin
        dur_eff   = (TABLE[note_idx].dur_ms == 16'd0) ? 16'd1 : TABLE[note_idx].dur_ms;
        target_ms = (state == PLAY) ? dur_eff : 16'(GAP_MS);
        phase_end = (state == PLAY || state == GAP) && ms_wrap &&
                    (ms_count == target_ms - 16'd1);
        advance   = phase_end && ((state == GAP) || !HAS_GAP);
        last_note = (note_idx == NIW'(NOTES - 1));
        next_idx  = last_note ? '0 : note_idx + NIW'(1);
    end

    // Restarting the timer on every phase change keeps each phase an exact multiple of a ms
    assign timer_clear = (state == IDLE) || phase_end || stop;
    assign timer_en    = (state != IDLE);

    ms_timer #(
        .FCLK (FCLK)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (timer_clear),
        .en       (timer_en),
        .ms_count (ms_count),
        .ms_wrap  (ms_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            freq     <= '0;
            onOff    <= 1'b0;
            busy     <= 1'b0;
            note_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                freq     <= '0;
                onOff    <= 1'b0;
                busy     <= 1'b0;
                note_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= PLAY;
                            note_idx <= '0;
                            freq     <= TABLE[0].freq;
                            onOff    <= (TABLE[0].freq != 32'd0);
                            busy     <= 1'b1;
                        end
                    end
                    PLAY, GAP: begin
                        if (state == PLAY && phase_end && HAS_GAP) begin
                            state <= GAP;
                            onOff <= 1'b0;
                        end else if (advance) begin
                            // loop only matters at the moment the last note finishes
                            if (!last_note || loop) begin
                                state    <= PLAY;
                                note_idx <= next_idx;
                                freq     <= TABLE[next_idx].freq;
                                onOff    <= (TABLE[next_idx].freq != 32'd0);
                            end else begin
                                state    <= IDLE;
                                freq     <= '0;
                                onOff    <= 1'b0;
                                busy     <= 1'b0;
                                note_idx <= '0;
                                done     <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        freq     <= '0;
                        onOff    <= 1'b0;
                        busy     <= 1'b0;
                        note_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: two instances (1 ms gap and no gap) share stimulus,
// each tracked by a timeline model that maps time-since-start to expected outputs.
module tb_melody_player;
    import melody_pkg::*;

    localparam int TB_FCLK  = 10_000;
    localparam int TB_TICKS = TB_FCLK / 1000;
    localparam int TB_NOTES = 3;
    localparam note_t [0:TB_NOTES-1] TB_TABLE = '{
        '{freq: 32'd440, dur_ms: 16'd3},
        '{freq: 32'd0,   dur_ms: 16'd2},
        '{freq: 32'd523, dur_ms: 16'd1}
    };

    typedef struct {
        logic [31:0] freq;
        logic        onOff;
        logic        busy;
        int          idx;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;

    logic [31:0] freq_g1, freq_g0;
    logic        onOff_g1, onOff_g0;
    logic        busy_g1, busy_g0;
    logic [1:0]  idx_g1, idx_g0;
    logic        done_g1, done_g0;

    int errors = 0;
    int checks = 0;

    int   gap_ms [2] = '{1, 0};
    int   note_freq [3] = '{440, 0, 523};
    int   note_dur  [3] = '{3, 2, 1};
    bit   active [2] = '{0, 0};
    int   pos [2] = '{0, 0};
    exp_t expv [2];

    always #5 clk = ~clk;

    melody_player #(
        .FCLK   (TB_FCLK),
        .NOTES  (TB_NOTES),
        .GAP_MS (1),
        .TABLE  (TB_TABLE)
    ) dut_g1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .freq     (freq_g1),
        .onOff    (onOff_g1),
        .busy     (busy_g1),
        .note_idx (idx_g1),
        .done     (done_g1)
    );

    melody_player #(
        .FCLK   (TB_FCLK),
        .NOTES  (TB_NOTES),
        .GAP_MS (0),
        .TABLE  (TB_TABLE)
    ) dut_g0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .freq     (freq_g0),
        .onOff    (onOff_g0),
        .busy     (busy_g0),
        .note_idx (idx_g0),
        .done     (done_g0)
    );

    function automatic exp_t mk(int f, bit on, bit b, int i, bit d);
        exp_t e;
        e.freq  = 32'(f);
        e.onOff = on;
        e.busy  = b;
        e.idx   = i;
        e.done  = d;
        return e;
    endfunction

    function automatic int period(int g);
        int total = 0;
        for (int i = 0; i < 3; i++) total += (note_dur[i] + g) * TB_TICKS;
        return total;
    endfunction

    // Position p cycles after the start edge, laid out as note/gap segments
    function automatic exp_t lookup(int p, int g);
        int rem = p;
        for (int i = 0; i < 3; i++) begin
            if (rem < note_dur[i] * TB_TICKS) return mk(note_freq[i], note_freq[i] != 0, 1'b1, i, 1'b0);
            rem -= note_dur[i] * TB_TICKS;
            if (rem < g * TB_TICKS) return mk(note_freq[i], 1'b0, 1'b1, i, 1'b0);
            rem -= g * TB_TICKS;
        end
        return mk(0, 1'b0, 1'b0, 0, 1'b0);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                active[k] = 1'b0;
                pos[k]    = 0;
                expv[k]   = mk(0, 1'b0, 1'b0, 0, 1'b0);
            end else if (stop) begin
                active[k] = 1'b0;
                expv[k]   = mk(0, 1'b0, 1'b0, 0, 1'b0);
            end else if (active[k]) begin
                pos[k] = pos[k] + 1;
                if (pos[k] == period(gap_ms[k])) begin
                    if (loop) begin
                        pos[k]  = 0;
                        expv[k] = lookup(0, gap_ms[k]);
                    end else begin
                        active[k] = 1'b0;
                        expv[k]   = mk(0, 1'b0, 1'b0, 0, 1'b1);
                    end
                end else begin
                    expv[k] = lookup(pos[k], gap_ms[k]);
                end
            end else if (start) begin
                active[k] = 1'b1;
                pos[k]    = 0;
                expv[k]   = lookup(0, gap_ms[k]);
            end else begin
                expv[k] = mk(0, 1'b0, 1'b0, 0, 1'b0);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("g1_freq",  freq_g1,               expv[0].freq);
        checkOutput("g1_onOff", 32'(onOff_g1),         32'(expv[0].onOff));
        checkOutput("g1_busy",  32'(busy_g1),          32'(expv[0].busy));
        checkOutput("g1_idx",   32'(idx_g1),           32'(expv[0].idx));
        checkOutput("g1_done",  32'(done_g1),          32'(expv[0].done));
        checkOutput("g0_freq",  freq_g0,               expv[1].freq);
        checkOutput("g0_onOff", 32'(onOff_g0),         32'(expv[1].onOff));
        checkOutput("g0_busy",  32'(busy_g0),          32'(expv[1].busy));
        checkOutput("g0_idx",   32'(idx_g0),           32'(expv[1].idx));
        checkOutput("g0_done",  32'(done_g0),          32'(expv[1].done));
    end

    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Hand-computed timeline: tone 1-30, gap 31-40, rest 41-60, gap 61-70, tone 71-80, gap 81-90, done 91
    task automatic runBasic(input bit poke);
        applyStimulus(1'b1, 1'b0);
        for (int n = 1; n <= 95; n++) begin
            case (n)
                1: begin
                    checkOutput("lit_g1_freq_c1", freq_g1, 32'd440);
                    checkOutput("lit_g1_on_c1", 32'(onOff_g1), 32'd1);
                end
                30: checkOutput("lit_g0_freq_c30", freq_g0, 32'd440);
                31: begin
                    checkOutput("lit_g1_on_c31", 32'(onOff_g1), 32'd0);
                    checkOutput("lit_g1_freq_c31", freq_g1, 32'd440);
                    checkOutput("lit_g0_freq_c31", freq_g0, 32'd0);
                end
                41: checkOutput("lit_g1_freq_c41", freq_g1, 32'd0);
                51: checkOutput("lit_g0_freq_c51", freq_g0, 32'd523);
                61: begin
                    checkOutput("lit_g0_done_c61", 32'(done_g0), 32'd1);
                    checkOutput("lit_g1_busy_c61", 32'(busy_g1), 32'd1);
                end
                62: checkOutput("lit_g0_busy_c62", 32'(busy_g0), 32'd0);
                71: begin
                    checkOutput("lit_g1_freq_c71", freq_g1, 32'd523);
                    checkOutput("lit_g1_idx_c71", 32'(idx_g1), 32'd2);
                end
                90: checkOutput("lit_g1_done_c90", 32'(done_g1), 32'd0);
                91: checkOutput("lit_g1_done_c91", 32'(done_g1), 32'd1);
                92: begin
                    checkOutput("lit_g1_done_c92", 32'(done_g1), 32'd0);
                    checkOutput("lit_g1_busy_c92", 32'(busy_g1), 32'd0);
                end
                default: ;
            endcase
            start = (poke && n == 20);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int doneSeen;
        reset_n = 1'b0;
        idleCycles(3);
        checkOutput("lit_reset_busy", 32'(busy_g1), 32'd0);
        checkOutput("lit_reset_freq", freq_g1, 32'd0);
        reset_n = 1'b1;
        idleCycles(2);

        $display("[TB] basic playback");
        runBasic(1'b0);
        idleCycles(3);

        $display("[TB] stop mid-note");
        applyStimulus(1'b1, 1'b0);
        idleCycles(14);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lit_stop_on", 32'(onOff_g1), 32'd0);
        checkOutput("lit_stop_freq", freq_g1, 32'd0);
        checkOutput("lit_stop_idx", 32'(idx_g1), 32'd0);
        checkOutput("lit_stop_busy", 32'(busy_g1), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 100; i++) begin
            if (done_g1 || done_g0) doneSeen++;
            @(negedge clk);
        end
        checkOutput("lit_stop_no_done", 32'(doneSeen), 32'd0);

        $display("[TB] looping");
        loop = 1'b1;
        applyStimulus(1'b1, 1'b0);
        for (int n = 1; n <= 100; n++) begin
            if (n == 61) checkOutput("lit_g0_loop_freq_c61", freq_g0, 32'd440);
            if (n == 90) checkOutput("lit_g1_loop_idx_c90", 32'(idx_g1), 32'd2);
            if (n == 91) begin
                checkOutput("lit_g1_loop_freq_c91", freq_g1, 32'd440);
                checkOutput("lit_g1_loop_on_c91", 32'(onOff_g1), 32'd1);
                checkOutput("lit_g1_loop_idx_c91", 32'(idx_g1), 32'd0);
                checkOutput("lit_g1_loop_done_c91", 32'(done_g1), 32'd0);
            end
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b1);
        loop = 1'b0;
        idleCycles(3);

        $display("[TB] start with stop from idle");
        applyStimulus(1'b1, 1'b1);
        checkOutput("lit_startstop_busy", 32'(busy_g1), 32'd0);
        idleCycles(3);

        $display("[TB] start while busy");
        runBasic(1'b1);
        idleCycles(3);

        $display("[TB] async reset mid-gap");
        applyStimulus(1'b1, 1'b0);
        idleCycles(34);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("lit_arst_freq", freq_g1, 32'd0);
        checkOutput("lit_arst_on", 32'(onOff_g1), 32'd0);
        checkOutput("lit_arst_busy", 32'(busy_g1), 32'd0);
        checkOutput("lit_arst_idx", 32'(idx_g1), 32'd0);
        idleCycles(2);
        reset_n = 1'b1;
        idleCycles(2);
        runBasic(1'b0);
        idleCycles(3);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Upstream stage for the square-wave tone generator.
- Steps through a fixed table of notes. Each note has a frequency in Hz and a duration in ms.
- Drives the tone generator's `freq` and `onOff` inputs, with a silent gap after every note.
- Started and stopped by single-cycle control pulses from the keypad/control logic. Can loop the melody.

Parameters:
- FCLK, 50_000_000, clock frequency in Hz; must be a multiple of 1000.
- NOTES, 8, number of table entries; must be ≥1.
- GAP_MS, 20, silent gap after each note in ms; 0 means no gap.
- TABLE, melody_pkg::DEFAULT_TABLE, array [NOTES] of note_t.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins playback from note 0.
- stop  in  1  one-cycle pulse; aborts playback.
- loop  in  1  level; when 1, playback restarts at note 0 after the last note.
- freq  out  32  frequency to the tone generator, Hz.
- onOff  out  1  1 = tone generator produces sound.
- busy  out  1  1 while not in IDLE.
- note_idx  out  $clog2(NOTES) (min 1)  index of the current note.
- done  out  1  one-cycle pulse when a non-looping melody completes.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; freq=0, onOff=0, busy=0, note_idx=0, done=0; ms counters cleared.
- All outputs are registered and change only on posedge clk.
- TICKS = FCLK/1000 cycles per ms. A tick counter and an ms counter are both cleared on entry to every PLAY or GAP state.
- A state lasting N ms occupies exactly N*TICKS cycles. dur_ms=0 is treated as 1.
- IDLE:
  - onOff=0, freq=0, busy=0.
  - start=1 → PLAY, note_idx=0.
- PLAY:
  - freq = TABLE[note_idx].freq.
  - onOff=1 if that freq≠0; a freq of 0 is a rest with onOff=0.
  - busy=1.
  - After dur_ms*TICKS cycles → GAP, or → ADVANCE directly if GAP_MS=0.
- GAP:
  - onOff=0; freq holds the last value.
  - After GAP_MS*TICKS cycles → ADVANCE.
- ADVANCE: a zero-length decision; it is not a separate cycle and is folded into the GAP/PLAY exit.
  - If note_idx<NOTES-1: note_idx+1 → PLAY.
  - Else if loop=1: note_idx=0 → PLAY.
  - Else: done=1 for one cycle → IDLE.
- loop is sampled only at the ADVANCE decision.
- stop=1 in any state → IDLE on the next edge: onOff=0, freq=0, note_idx=0, no done pulse.
- start while busy is ignored.
- start and stop in the same cycle: stop wins.
- Reset mid-note returns immediately to reset values.
- Counter widths:
  - tick counter: $clog2(TICKS).
  - ms counter: 16 bits, matching dur_ms.
  - No overflow is possible for legal parameters.

Decomposition:
- melody_pkg:
  - `typedef struct packed { logic [31:0] freq; logic [15:0] dur_ms; } note_t`.
  - state enum `{IDLE, PLAY, GAP}`.
  - DEFAULT_TABLE: C4 262, D4 294, E4 330, F4 349, G4 392, A4 440, B4 494, C5 523, each 250 ms.
- Sub-module ms_timer:
  - Parameter FCLK; inputs clear and en; outputs ms_count[15:0].
  - Counts whole ms since the last clear.
  - Used by melody_player for both PLAY and GAP durations.

Test Plan (FCLK=10_000 → TICKS=10, GAP_MS=1, NOTES=3, TABLE={440,3},{0,2},{523,1}, loop=0):
- Basic playback:
  - Stimulus: start pulse at edge 0.
  - Required response:
    - freq=440, onOff=1 for cycles 1–30.
    - onOff=0 for cycles 31–40.
    - Rest (freq=0, onOff=0) for cycles 41–60.
    - Gap for cycles 61–70.
    - freq=523, onOff=1 for cycles 71–80.
    - Gap for cycles 81–90.
    - done=1 at cycle 91 only, then IDLE with busy=0.
- Stop mid-note: stop pulse during cycle 15 → next cycle onOff=0, freq=0, note_idx=0, busy=0; done never asserted.
- Looping: loop=1 held → after cycle 90, freq=440, onOff=1 again at cycle 91; no done pulse; note_idx wraps 2→0.
- Start/stop and start-while-busy:
  - start and stop asserted together from IDLE → remains IDLE.
  - start pulse at cycle 20 while playing → ignored; timing identical to the basic-playback scenario.
- Async reset: reset_n low at cycle 35 (mid-gap, not on a clock edge) → all outputs 0 immediately. After release, a new start reproduces the basic-playback scenario exactly.
- GAP_MS=0 variant: notes play back-to-back: freq 440 for cycles 1–30, rest 31–50, 523 for 51–60, done at 61.
